// File: rtl/fxp_mul_pipe.sv
// fxp_mul_pipe
// Pipelined signed fixed-point multiplier (QI.F, W = INT_BITS + FRAC_BITS)
// with valid/ready handshaking, optional round-half-up and optional
// saturation. The whole pipe advances or stalls as one unit.
//
// Ports:
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset
//   in_valid   operand pair present
//   in_ready   operands accepted this cycle (= pipeline advance)
//   a, b       signed QI.F operands
//   out_valid  result present
//   out_ready  downstream accepts result
//   out        signed QI.F product (held while stalled or during bubbles)
//   overflow   product exceeded QI.F range; qualified by out_valid
//
// Latency is STAGES cycles of registers (legal 1..4): a pair accepted at
// edge k is presented after edge k+STAGES-1.
module fxp_mul_pipe #(
  parameter int INT_BITS  = 10,
  parameter int FRAC_BITS = 22,
  parameter int STAGES    = 3,
  parameter int ROUND     = 1,
  parameter int SATURATE  = 1,
  localparam int W        = INT_BITS + FRAC_BITS
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out,
  output logic         overflow
);

  localparam int PW = 2 * W;
  localparam int RW = 2 * W - FRAC_BITS;
  localparam logic [PW-1:0] RND_K = (ROUND != 0) ? (PW'(1) << (FRAC_BITS - 1)) : '0;

  logic                 advance;
  logic                 v_fin;
  logic signed [PW-1:0] p_fin;

  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  // p_fin/v_fin: full product and its valid bit as seen by the output stage.
  generate
    if (STAGES == 1) begin : g_s1
      assign p_fin = PW'($signed(a)) * PW'($signed(b));
      assign v_fin = in_valid;
    end else begin : g_sn
      logic signed [W-1:0]  a_q;
      logic signed [W-1:0]  b_q;
      logic                 v1;
      logic signed [PW-1:0] p1;

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          a_q <= '0;
          b_q <= '0;
          v1  <= 1'b0;
        end else if (advance) begin
          a_q <= a;
          b_q <= b;
          v1  <= in_valid;
        end
      end

      assign p1 = PW'(a_q) * PW'(b_q);

      if (STAGES == 2) begin : g_s2
        assign p_fin = p1;
        assign v_fin = v1;
      end else begin : g_s34
        logic signed [PW-1:0] p_q;
        logic                 v2;

        always_ff @(posedge clk or negedge reset_n) begin
          if (!reset_n) begin
            p_q <= '0;
            v2  <= 1'b0;
          end else if (advance) begin
            p_q <= p1;
            v2  <= v1;
          end
        end

        if (STAGES == 3) begin : g_s3
          assign p_fin = p_q;
          assign v_fin = v2;
        end else begin : g_s4
          logic signed [PW-1:0] p_d;
          logic                 v3;

          always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
              p_d <= '0;
              v3  <= 1'b0;
            end else if (advance) begin
              p_d <= p_q;
              v3  <= v2;
            end
          end

          assign p_fin = p_d;
          assign v_fin = v3;
        end
      end
    end
  endgenerate

  logic [RW-1:0]  r;
  logic [RW-W:0]  r_hi;
  logic           ovf_c;
  logic [W-1:0]   res_c;

  // Rounding constant is added before the shift; taking the upper RW bits of
  // the sum is the arithmetic right shift by FRAC_BITS.
  always_comb begin
    r     = RW'((p_fin + RND_K) >> FRAC_BITS);
    r_hi  = r[RW-1:W-1];
    ovf_c = !((&r_hi) || !(|r_hi));
    res_c = r[W-1:0];
    if (ovf_c && (SATURATE != 0)) begin
      res_c = r[RW-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end
  end

  // Data only loads on a valid token so a bubble leaves out unchanged.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out       <= '0;
      overflow  <= 1'b0;
    end else if (advance) begin
      out_valid <= v_fin;
      if (v_fin) begin
        out      <= res_c;
        overflow <= ovf_c;
      end
    end
  end

endmodule

// File: tb/tb_fxp_mul_pipe.sv
// tb_fxp_mul_pipe
// Self-checking bench for fxp_mul_pipe. Five instances share one stimulus:
//   0: defaults (STAGES=3, round, saturate)   1: STAGES=3, truncate, wrap
//   2: STAGES=1   3: STAGES=2   4: STAGES=4   (2..4 round + saturate)
// Expected values come from directed constants and a longint reference model.
module tb_fxp_mul_pipe;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset_n = 1'b1;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b1;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;

  logic         o_val [5];
  logic         o_rdy [5];
  logic         o_ovf [5];
  logic [W-1:0] o_out [5];

  int errs = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fxp_mul_pipe u_def (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(o_rdy[0]),
    .a(a), .b(b), .out_valid(o_val[0]), .out_ready(out_ready),
    .out(o_out[0]), .overflow(o_ovf[0]));

  fxp_mul_pipe #(.ROUND(0), .SATURATE(0)) u_wrap (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(o_rdy[1]),
    .a(a), .b(b), .out_valid(o_val[1]), .out_ready(out_ready),
    .out(o_out[1]), .overflow(o_ovf[1]));

  fxp_mul_pipe #(.STAGES(1)) u_st1 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(o_rdy[2]),
    .a(a), .b(b), .out_valid(o_val[2]), .out_ready(out_ready),
    .out(o_out[2]), .overflow(o_ovf[2]));

  fxp_mul_pipe #(.STAGES(2)) u_st2 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(o_rdy[3]),
    .a(a), .b(b), .out_valid(o_val[3]), .out_ready(out_ready),
    .out(o_out[3]), .overflow(o_ovf[3]));

  fxp_mul_pipe #(.STAGES(4)) u_st4 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(o_rdy[4]),
    .a(a), .b(b), .out_valid(o_val[4]), .out_ready(out_ready),
    .out(o_out[4]), .overflow(o_ovf[4]));

  // Edges from acceptance to first visible result, per instance.
  int lat [5] = '{2, 2, 0, 1, 3};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, want);
    end
  endtask

  // Q10.22 product by plain integer arithmetic.
  function automatic void model(input logic [31:0] x, input logic [31:0] y,
                                input bit rnd, input bit sat,
                                output logic [31:0] r, output logic ov);
    longint p;
    longint q;
    p = longint'($signed(x)) * longint'($signed(y));
    if (rnd) p = p + (longint'(1) <<< 21);
    q = p >>> 22;
    ov = (q > 64'sd2147483647) || (q < -64'sd2147483648);
    if (ov && sat) r = (q < 0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
    else           r = q[31:0];
  endfunction

  // One isolated transaction; checks latency and result on every instance.
  task automatic single(input logic [31:0] ta, input logic [31:0] tb,
                        input logic [31:0] ed, input logic od,
                        input logic [31:0] ew, input logic ow, input string tag);
    int          seen [5];
    logic [31:0] co [5];
    logic        cv [5];
    for (int i = 0; i < 5; i++) begin
      seen[i] = -1;
      co[i]   = 'x;
      cv[i]   = 1'bx;
    end
    a = ta; b = tb; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int n = 0; n < 6; n++) begin
      for (int i = 0; i < 5; i++) begin
        if (seen[i] < 0 && o_val[i]) begin
          seen[i] = n;
          co[i]   = o_out[i];
          cv[i]   = o_ovf[i];
        end
      end
      @(posedge clk); #1;
    end
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("%s_lat%0d", tag, i), 32'(seen[i]), 32'(lat[i]));
      chk($sformatf("%s_out%0d", tag, i), co[i], (i == 1) ? ew : ed);
      chk($sformatf("%s_ovf%0d", tag, i), 32'(cv[i]), 32'((i == 1) ? ow : od));
    end
  endtask

  logic [31:0] da [8];
  logic [31:0] db [8];
  logic [31:0] ed [8];
  logic [31:0] ew [8];
  logic        od [8];
  logic        ow [8];

  logic [31:0] ra [6];
  logic [31:0] rb [6];
  int          got [5];
  logic [31:0] eo;
  logic        ev;
  logic [31:0] xr;
  logic [31:0] yr;

  logic [31:0] qa [8];
  logic [31:0] qb [8];
  int          pat [16] = '{1, 0, 0, 1, 0, 1, 1, 1, 0, 0, 1, 0, 1, 1, 0, 1};
  int          nacc;
  int          nout;
  logic        acc;
  logic        held_v;
  logic [31:0] held_o;
  logic        held_ov;

  initial begin
    da = '{32'h0020_0000, 32'hFFA0_0000, 32'h6400_0000, 32'h9C00_0000,
           32'h8000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 32'h07FF_F800};
    db = '{32'h0028_0000, 32'h0060_0000, 32'h0100_0000, 32'h0100_0000,
           32'h8000_0000, 32'h0020_0000, 32'h0020_0000, 32'h0400_0400};
    ed = '{32'h0014_0000, 32'hFF70_0000, 32'h7FFF_FFFF, 32'h8000_0000,
           32'h7FFF_FFFF, 32'h0000_0001, 32'h0000_0000, 32'h7FFF_FFFF};
    od = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    ew = '{32'h0014_0000, 32'hFF70_0000, 32'h9000_0000, 32'h7000_0000,
           32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF};
    ow = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

    // Asynchronous reset before any clock edge.
    #1 reset_n = 1'b0;
    #1;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("rst_valid%0d", i), 32'(o_val[i]), 32'd0);
      chk($sformatf("rst_out%0d", i), o_out[i], 32'd0);
      chk($sformatf("rst_ovf%0d", i), 32'(o_ovf[i]), 32'd0);
    end
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Directed arithmetic, rounding and saturation corners.
    for (int j = 0; j < 8; j++)
      single(da[j], db[j], ed[j], od[j], ew[j], ow[j], $sformatf("dir%0d", j));

    // Back-to-back random stream with out_ready held high.
    for (int j = 0; j < 6; j++) begin
      xr = $urandom;
      yr = $urandom;
      if (j % 2 == 1) begin
        xr = {{8{xr[23]}}, xr[23:0]};
        yr = {{8{yr[23]}}, yr[23:0]};
      end
      ra[j] = xr;
      rb[j] = yr;
    end
    for (int i = 0; i < 5; i++) got[i] = 0;
    for (int n = 0; n < 12; n++) begin
      if (n < 6) begin
        a = ra[n]; b = rb[n]; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk); #1;
      for (int i = 0; i < 5; i++) begin
        if (o_val[i]) begin
          chk($sformatf("b2b_cyc%0d", i), 32'(n), 32'(lat[i] + got[i]));
          if (got[i] < 6) begin
            model(ra[got[i]], rb[got[i]], i != 1, i != 1, eo, ev);
            chk($sformatf("b2b_out%0d_%0d", i, got[i]), o_out[i], eo);
            chk($sformatf("b2b_ovf%0d_%0d", i, got[i]), 32'(o_ovf[i]), 32'(ev));
          end
          got[i]++;
        end
      end
    end
    for (int i = 0; i < 5; i++)
      chk($sformatf("b2b_count%0d", i), 32'(got[i]), 32'd6);

    // Backpressure on the default instance.
    for (int j = 0; j < 8; j++) begin
      qa[j] = $urandom;
      qb[j] = $urandom_range(32'h00FF_FFFF, 0);
    end
    nacc = 0; nout = 0; held_v = 1'b0; held_o = '0; held_ov = 1'b0;
    for (int c = 0; c < 80 && nout < 8; c++) begin
      out_ready = (c < 16) ? (pat[c] != 0) : 1'b1;
      in_valid  = (nacc < 8);
      if (nacc < 8) begin
        a = qa[nacc]; b = qb[nacc];
      end
      @(negedge clk);
      if (held_v) begin
        chk("stall_valid", 32'(o_val[0]), 32'd1);
        chk("stall_out", o_out[0], held_o);
        chk("stall_ovf", 32'(o_ovf[0]), 32'(held_ov));
      end
      chk("bp_in_ready", 32'(o_rdy[0]), 32'(!(o_val[0] && !out_ready)));
      acc     = in_valid && o_rdy[0];
      held_v  = o_val[0] && !out_ready;
      held_o  = o_out[0];
      held_ov = o_ovf[0];
      if (o_val[0] && out_ready) begin
        model(qa[nout], qb[nout], 1'b1, 1'b1, eo, ev);
        chk($sformatf("bp_out%0d", nout), o_out[0], eo);
        chk($sformatf("bp_ovf%0d", nout), 32'(o_ovf[0]), 32'(ev));
        nout++;
      end
      @(posedge clk); #1;
      if (acc) nacc++;
    end
    chk("bp_count", 32'(nout), 32'd8);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      chk("bp_no_extra", 32'(o_val[0]), 32'd0);
    end
    @(posedge clk); #1;

    // Reset with tokens in flight, between clock edges.
    for (int k = 0; k < 3; k++) begin
      a = da[k]; b = db[k]; in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("pre_reset_valid", 32'(o_val[0]), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("mid_rst_valid%0d", i), 32'(o_val[i]), 32'd0);
      chk($sformatf("mid_rst_out%0d", i), o_out[i], 32'd0);
      chk($sformatf("mid_rst_ovf%0d", i), 32'(o_ovf[i]), 32'd0);
    end
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    for (int n = 0; n < 5; n++) begin
      for (int i = 0; i < 5; i++)
        chk($sformatf("post_rst_idle%0d", i), 32'(o_val[i]), 32'd0);
      @(posedge clk); #1;
    end
    single(da[1], db[1], ed[1], od[1], ew[1], ow[1], "post_rst");

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
